// File: rtl/p2s_chain.sv
// Parallel-to-serial shifter for daisy-chained 74HC595-style peripherals: one frame of
// NUM_WORDS*DATA_BITS bits on sclk/sout, framed by sen. Optional macro P2S_CHAIN_START_SYNC_EN.
module p2s_chain #(
  parameter int DATA_BITS = 16,
  parameter int NUM_WORDS = 4,
  parameter int DIR       = 0,
  parameter int CLK_DIV   = 2
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [DATA_BITS*NUM_WORDS-1:0] data,
  output logic                           ready,
  output logic                           sclk,
  output logic                           sout,
  output logic                           sen,
  output logic                           done,
  output logic [1:0]                     dbg_state
);

  localparam int TOTAL = DATA_BITS * NUM_WORDS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD} state_t;

  state_t           state;
  logic [TOTAL-1:0] shreg;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             req;
  logic             accept;
  logic             div_last;
  logic             out_bit;

`ifdef P2S_CHAIN_START_SYNC_EN
  // Two synchroniser stages plus one history flop for the rising-edge detector.
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], start};
    end
  end

  assign req = sync[1] & ~sync[2];
`else
  assign req = start;
`endif

  // Handshake: a request is accepted on the rising edge where req=1 and ready=1.
  // ready is only ever high while the FSM sits in IDLE, so acceptance needs no state term.
  assign accept    = req & ready;
  assign div_last  = (div == DIV_MAX);
  assign out_bit   = (DIR == 0) ? shreg[TOTAL-1] : shreg[0];
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      shreg <= '0;
      div   <= '0;
      cnt   <= '0;
      ready <= 1'b1;
      sen   <= 1'b1;
      sclk  <= 1'b0;
      sout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= data;
            cnt   <= '0;
            div   <= '0;
            state <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (div_last) begin
            div   <= '0;
            state <= SHIFT_HI;
          end else begin
            div <= div + 1'b1;
          end
        end
        SHIFT_HI: begin
          if (div_last) begin
            div   <= '0;
            shreg <= (DIR == 0) ? (shreg << 1) : (shreg >> 1);
            cnt   <= cnt + 1'b1;
            state <= (cnt == CNT_LAST) ? HOLD : SHIFT_LO;
          end else begin
            div <= div + 1'b1;
          end
        end
        HOLD: begin
          if (div_last) begin
            div   <= '0;
            state <= IDLE;
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Pin flops follow the FSM one cycle behind, so sout is set up a full
      // half-period before sclk rises and done lines up with sen returning high.
      ready <= (state == IDLE) && !accept;
      sen   <= (state == IDLE);
      sclk  <= (state == SHIFT_HI);
      done  <= (state == IDLE) && !sen;
      case (state)
        SHIFT_LO: sout <= out_bit;
        SHIFT_HI: sout <= sout;
        default:  sout <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_chain.sv
// Directed bench for p2s_chain: an MSB-first and an LSB-first instance share clk/rstn/start
// and are fed the same frames from a vector table, plus hand-written corner sequences.
module tb_p2s_chain;

  localparam int DATA_BITS = 8;
  localparam int NUM_WORDS = 2;
  localparam int CLK_DIV   = 2;
  localparam int TOTAL     = DATA_BITS * NUM_WORDS;
  localparam int EXP_LAT   = 1 + 2 * CLK_DIV * TOTAL + CLK_DIV;
`ifdef P2S_CHAIN_START_SYNC_EN
  localparam int ACC_LAT = 2;
`else
  localparam int ACC_LAT = 0;
`endif

  typedef struct {
    logic [15:0] data;
    logic [15:0] exp_msb;
    logic [15:0] exp_lsb;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] data;
  logic        ready_m, sclk_m, sout_m, sen_m, done_m;
  logic        ready_l, sclk_l, sout_l, sen_l, done_l;
  logic [1:0]  state_m, state_l;

  int n_checks = 0;
  int n_fail   = 0;

  p2s_chain #(.DATA_BITS(DATA_BITS), .NUM_WORDS(NUM_WORDS), .DIR(0), .CLK_DIV(CLK_DIV)) u_msb (
    .clk(clk), .rstn(rstn), .start(start), .data(data),
    .ready(ready_m), .sclk(sclk_m), .sout(sout_m), .sen(sen_m), .done(done_m),
    .dbg_state(state_m)
  );

  p2s_chain #(.DATA_BITS(DATA_BITS), .NUM_WORDS(NUM_WORDS), .DIR(1), .CLK_DIV(CLK_DIV)) u_lsb (
    .clk(clk), .rstn(rstn), .start(start), .data(data),
    .ready(ready_l), .sclk(sclk_l), .sout(sout_l), .sen(sen_l), .done(done_l),
    .dbg_state(state_l)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observes both instances from just after the accepting edge until both raise done
  // (bounded). pulse_at > 0 pulses start for one cycle while the frame is busy.
  task automatic watch(input int pulse_at,
                       output logic [15:0] seq_m, output logic [15:0] seq_l,
                       output int edges_m, output int edges_l,
                       output int lat_m, output int lat_l, output int sen_bad);
    logic pm, pl;
    seq_m = '0; seq_l = '0; edges_m = 0; edges_l = 0;
    lat_m = 0; lat_l = 0; sen_bad = 0;
    pm = sclk_m; pl = sclk_l;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (pulse_at > 0 && k == pulse_at) start = 1'b1;
      else if (pulse_at > 0 && k == pulse_at + 1) start = 1'b0;
      if (sclk_m && !pm) begin
        seq_m = {seq_m[14:0], sout_m};
        edges_m++;
        if (sen_m) sen_bad++;
      end
      if (sclk_l && !pl) begin
        seq_l = {seq_l[14:0], sout_l};
        edges_l++;
        if (sen_l) sen_bad++;
      end
      pm = sclk_m; pl = sclk_l;
      if (done_m && lat_m == 0) lat_m = k;
      if (done_l && lat_l == 0) lat_l = k;
      if (lat_m != 0 && lat_l != 0) break;
    end
  endtask

  // Driver: raise start, wait for the accepting edge, then scramble data to show it is ignored.
  task automatic launch(input logic [15:0] d, input logic keep_start);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    repeat (ACC_LAT) @(posedge clk);
    @(posedge clk); #1;
    if (!keep_start) start = 1'b0;
    data = ~d;
    check("accept_state_msb", 32'(state_m), 32'd1);
    check("accept_ready_msb", 32'(ready_m), 32'd0);
  endtask

  task automatic frame_checks(input string tag, input logic [15:0] exp_m, input logic [15:0] exp_l,
                              input logic [15:0] seq_m, input logic [15:0] seq_l,
                              input int edges_m, input int edges_l,
                              input int lat_m, input int lat_l, input int sen_bad);
    check({tag, "_seq_msb"}, 32'(seq_m), 32'(exp_m));
    check({tag, "_seq_lsb"}, 32'(seq_l), 32'(exp_l));
    check({tag, "_edges_msb"}, 32'(edges_m), 32'(TOTAL));
    check({tag, "_edges_lsb"}, 32'(edges_l), 32'(TOTAL));
    check({tag, "_lat_msb"}, 32'(lat_m), 32'(EXP_LAT));
    check({tag, "_lat_lsb"}, 32'(lat_l), 32'(EXP_LAT));
    check({tag, "_sen_low"}, 32'(sen_bad), 32'd0);
    check({tag, "_sen_at_done"}, 32'(sen_m), 32'd1);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [15:0] sm, sl;
    int          em, el, lm, ll, sb, cnt, pm;

    vecs[0] = '{data: 16'hA5C3, exp_msb: 16'hA5C3, exp_lsb: 16'hC3A5};
    vecs[1] = '{data: 16'h0001, exp_msb: 16'h0001, exp_lsb: 16'h8000};
    vecs[2] = '{data: 16'hFFFF, exp_msb: 16'hFFFF, exp_lsb: 16'hFFFF};
    vecs[3] = '{data: 16'h1234, exp_msb: 16'h1234, exp_lsb: 16'h2C48};
    vecs[4] = '{data: 16'h8000, exp_msb: 16'h8000, exp_lsb: 16'h0001};

    rstn  = 1'b1;
    start = 1'b0;
    data  = '0;
    #3 rstn = 1'b0;
    #1;
    check("rst_ready_msb", 32'(ready_m), 32'd1);
    check("rst_sen_msb",   32'(sen_m),   32'd1);
    check("rst_sclk_msb",  32'(sclk_m),  32'd0);
    check("rst_sout_msb",  32'(sout_m),  32'd0);
    check("rst_done_msb",  32'(done_m),  32'd0);
    check("rst_state_msb", 32'(state_m), 32'd0);
    check("rst_ready_lsb", 32'(ready_l), 32'd1);
    check("rst_sen_lsb",   32'(sen_l),   32'd1);
    check("rst_sclk_lsb",  32'(sclk_l),  32'd0);
    check("rst_done_lsb",  32'(done_l),  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames, each started in the previous frame's done cycle.
    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].data, 1'b0);
      watch(0, sm, sl, em, el, lm, ll, sb);
      frame_checks($sformatf("vec%0d", i), vecs[i].exp_msb, vecs[i].exp_lsb,
                   sm, sl, em, el, lm, ll, sb);
    end

    // Start pulsed mid-frame is ignored and does not queue a second frame.
    launch(16'h5A3C, 1'b0);
    watch(20, sm, sl, em, el, lm, ll, sb);
    frame_checks("busy", 16'h5A3C, 16'h3C5A, sm, sl, em, el, lm, ll, sb);
    repeat (4) @(posedge clk);
    #1;
    check("busy_no_requeue_state", 32'(state_m), 32'd0);
    check("busy_no_requeue_sen", 32'(sen_m), 32'd1);

`ifndef P2S_CHAIN_START_SYNC_EN
    // Start held high: the next frame is accepted in the done cycle.
    launch(16'hA5C3, 1'b1);
    watch(0, sm, sl, em, el, lm, ll, sb);
    frame_checks("b2b1", 16'hA5C3, 16'hC3A5, sm, sl, em, el, lm, ll, sb);
    check("b2b_ready_at_done", 32'(ready_m), 32'd1);
    data = 16'h0F0F;
    @(posedge clk); #1;
    start = 1'b0;
    data  = 16'hFFFF;
    check("b2b_zero_gap_state", 32'(state_m), 32'd1);
    watch(0, sm, sl, em, el, lm, ll, sb);
    frame_checks("b2b2", 16'h0F0F, 16'hF0F0, sm, sl, em, el, lm, ll, sb);
`else
    // Start held high for 200 cycles gives exactly one frame.
    @(negedge clk);
    data  = 16'hA5C3;
    start = 1'b1;
    cnt   = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (done_m) cnt++;
    end
    start = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done_m) cnt++;
    end
    check("sync_hold_one_done", 32'(cnt), 32'd1);
`endif

    // Abort: reset asserted while bit 5 is on the pins.
    @(negedge clk);
    data  = 16'hA5C3;
    start = 1'b1;
    repeat (ACC_LAT) @(posedge clk);
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    pm  = 0;
    for (int k = 0; k < 200 && cnt < 6; k++) begin
      @(posedge clk); #1;
      if (sclk_m && pm == 0) cnt++;
      pm = int'(sclk_m);
    end
    check("abort_reached_bit5", 32'(cnt), 32'd6);
    check("abort_pre_sout", 32'(sout_m), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("abort_ready", 32'(ready_m), 32'd1);
    check("abort_sen",   32'(sen_m),   32'd1);
    check("abort_sclk",  32'(sclk_m),  32'd0);
    check("abort_sout",  32'(sout_m),  32'd0);
    check("abort_state", 32'(state_m), 32'd0);
    @(negedge clk) rstn = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!sen_m || done_m || !sen_l || done_l) cnt++;
    end
    check("abort_no_partial_latch", 32'(cnt), 32'd0);
    launch(16'hA5C3, 1'b0);
    watch(0, sm, sl, em, el, lm, ll, sb);
    frame_checks("post_abort", 16'hA5C3, 16'hC3A5, sm, sl, em, el, lm, ll, sb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
